// File: rtl/display_refresher_if.sv
// rtl/display_refresher_if.sv - SPI command and pixel-read signals between refresher, SPI engine and content source
// master: the refresher (drives dspi_cmd/dspi_byte, d_read/d_page_idx/d_column_idx, frame_done)
// slave : the SPI engine plus content source (drive dspi_ready, d_data, d_data_ready)
interface display_refresher_if;
  logic       dspi_ready;
  logic [2:0] dspi_cmd;
  logic [7:0] dspi_byte;
  logic       d_read;
  logic [2:0] d_page_idx;
  logic [6:0] d_column_idx;
  logic [7:0] d_data;
  logic       d_data_ready;
  logic       frame_done;

  modport master (
    input  dspi_ready, d_data, d_data_ready,
    output dspi_cmd, dspi_byte, d_read, d_page_idx, d_column_idx, frame_done
  );

  modport slave (
    output dspi_ready, d_data, d_data_ready,
    input  dspi_cmd, dspi_byte, d_read, d_page_idx, d_column_idx, frame_done
  );
endinterface

// File: rtl/display_refresher.sv
// rtl/display_refresher.sv - OLED power-up then continuous page/column refresh sequencer
// Ports:
//   clk   - system clock
//   rst_n - asynchronous active-low reset
//   bus   - display_refresher_if.master: dspi_ready/dspi_cmd/dspi_byte toward the SPI engine,
//           d_read/d_page_idx/d_column_idx/d_data/d_data_ready toward the content source,
//           frame_done pulse after the last byte of each frame.
// Optional: define DISPLAY_REFRESHER_TIMEOUT_EN to stop waiting for d_data_ready after TIMEOUT cycles
//           (a 0x00 byte is sent in place of the missing column).
module display_refresher #(
  parameter int PAGES   = 8,
  parameter int COLUMNS = 128,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  display_refresher_if.master bus
);

  localparam logic [2:0] CMD_NOP   = 3'd0;
  localparam logic [2:0] CMD_RESET = 3'd1;
  localparam logic [2:0] CMD_CTRL  = 3'd2;
  localparam logic [2:0] CMD_DATA  = 3'd3;

  localparam logic [2:0] LAST_PAGE = 3'(PAGES - 1);
  localparam logic [6:0] LAST_COL  = 7'(COLUMNS - 1);
  localparam logic [2:0] LAST_INIT = 3'd5;
  localparam logic [1:0] LAST_SETUP = 2'd2;

  typedef enum logic [2:0] {
    S_RST,
    S_INIT,
    S_PAGE,
    S_REQ,
    S_WAIT,
    S_SEND
  } state_t;

  state_t     state, state_n;
  logic [2:0] init_ptr, init_ptr_n;
  logic [1:0] setup_ptr, setup_ptr_n;
  logic       guard, guard_n;
  logic [2:0] page, page_n;
  logic [6:0] column, column_n;
  logic [7:0] data_q, data_n;

  logic       can_issue;
  logic [2:0] cmd;
  logic [7:0] cmd_byte;
  logic       read;
  logic       done;

`ifdef DISPLAY_REFRESHER_TIMEOUT_EN
  // The d_read cycle counts as the first elapsed cycle, so the counter starts at 1
  // and the forced 0x00 byte is issued exactly TIMEOUT cycles after d_read.
  localparam logic [3:0] WAIT_LAST = 4'(TIMEOUT - 1);
  logic [3:0] wait_cnt, wait_cnt_n;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  // Power-up sequence: display off, charge pump setting, charge pump on,
  // addressing mode, page addressing, display on.
  function automatic logic [7:0] init_rom(input logic [2:0] idx);
    case (idx)
      3'd0:    init_rom = 8'hAE;
      3'd1:    init_rom = 8'h8D;
      3'd2:    init_rom = 8'h14;
      3'd3:    init_rom = 8'h20;
      3'd4:    init_rom = 8'h02;
      default: init_rom = 8'hAF;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_RST;
      init_ptr  <= 3'd0;
      setup_ptr <= 2'd0;
      guard     <= 1'b0;
      page      <= 3'd0;
      column    <= 7'd0;
      data_q    <= 8'd0;
`ifdef DISPLAY_REFRESHER_TIMEOUT_EN
      wait_cnt  <= 4'd0;
`endif
    end else begin
      state     <= state_n;
      init_ptr  <= init_ptr_n;
      setup_ptr <= setup_ptr_n;
      guard     <= guard_n;
      page      <= page_n;
      column    <= column_n;
      data_q    <= data_n;
`ifdef DISPLAY_REFRESHER_TIMEOUT_EN
      wait_cnt  <= wait_cnt_n;
`endif
    end
  end

  always_comb begin
    state_n     = state;
    init_ptr_n  = init_ptr;
    setup_ptr_n = setup_ptr;
    page_n      = page;
    column_n    = column;
    data_n      = data_q;
    cmd         = CMD_NOP;
    cmd_byte    = 8'd0;
    read        = 1'b0;
    done        = 1'b0;
`ifdef DISPLAY_REFRESHER_TIMEOUT_EN
    wait_cnt_n  = wait_cnt;
`endif
    // The engine needs one cycle after an issue to drop ready, so ready is
    // not trusted in the cycle right after we issued.
    can_issue = bus.dspi_ready && !guard;

    case (state)
      S_RST: begin
        if (can_issue) begin
          cmd     = CMD_RESET;
          state_n = S_INIT;
        end
      end

      S_INIT: begin
        if (can_issue) begin
          cmd      = CMD_CTRL;
          cmd_byte = init_rom(init_ptr);
          if (init_ptr == LAST_INIT) begin
            init_ptr_n = 3'd0;
            page_n     = 3'd0;
            column_n   = 7'd0;
            state_n    = S_PAGE;
          end else begin
            init_ptr_n = init_ptr + 3'd1;
          end
        end
      end

      S_PAGE: begin
        // Page address, then column low/high nibble reset to column 0.
        if (can_issue) begin
          cmd = CMD_CTRL;
          case (setup_ptr)
            2'd0:    cmd_byte = {5'b10110, page};
            2'd1:    cmd_byte = 8'h00;
            default: cmd_byte = 8'h10;
          endcase
          if (setup_ptr == LAST_SETUP) begin
            setup_ptr_n = 2'd0;
            state_n     = S_REQ;
          end else begin
            setup_ptr_n = setup_ptr + 2'd1;
          end
        end
      end

      S_REQ: begin
        read    = 1'b1;
        state_n = S_WAIT;
`ifdef DISPLAY_REFRESHER_TIMEOUT_EN
        wait_cnt_n = 4'd1;
`endif
      end

      S_WAIT: begin
        if (bus.d_data_ready) begin
          data_n  = bus.d_data;
          state_n = S_SEND;
        end
`ifdef DISPLAY_REFRESHER_TIMEOUT_EN
        else if (wait_cnt == WAIT_LAST) begin
          data_n  = 8'h00;
          state_n = S_SEND;
        end else begin
          wait_cnt_n = wait_cnt + 4'd1;
        end
`endif
      end

      S_SEND: begin
        if (can_issue) begin
          cmd      = CMD_DATA;
          cmd_byte = data_q;
          if (column != LAST_COL) begin
            column_n = column + 7'd1;
            state_n  = S_REQ;
          end else begin
            column_n = 7'd0;
            state_n  = S_PAGE;
            if (page != LAST_PAGE) begin
              page_n = page + 3'd1;
            end else begin
              page_n = 3'd0;
              done   = 1'b1;
            end
          end
        end
      end

      default: state_n = S_RST;
    endcase

    guard_n = (cmd != CMD_NOP);
  end

  // Strobes are decoded from state and the live dspi_ready, so they are
  // forced low while reset is held to keep S_RST from issuing during reset.
  assign bus.dspi_cmd     = rst_n ? cmd : CMD_NOP;
  assign bus.dspi_byte    = rst_n ? cmd_byte : 8'd0;
  assign bus.d_read       = rst_n & read;
  assign bus.frame_done   = rst_n & done;
  assign bus.d_page_idx   = page;
  assign bus.d_column_idx = column;

endmodule

// File: tb/tb_display_refresher.sv
// tb/tb_display_refresher.sv - randomized self-checking bench for display_refresher
module tb_display_refresher;
  localparam int TIMEOUT = 15;
  localparam logic [7:0] INIT_BYTES [6] = '{8'hAE, 8'h8D, 8'h14, 8'h20, 8'h02, 8'hAF};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  display_refresher_if bus_if();

  display_refresher dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  int ready_mode = 0;
  int lat_min = 2;
  int lat_max = 2;
  bit rand_data = 0;
  logic [7:0] fix_val = 8'h5A;
  bit silent = 0;
  bit spurious = 0;

  int strobe_at = -1;
  logic [7:0] resp_data = 8'h00;

  int k = 0;
  bit prev_issue = 0;
  bit arrived = 0;
  bit waiting = 0;
  logic [7:0] exp_data = 8'h00;
  int read_cyc = -1;
  int read_pg = -1;
  int read_col = -1;
  int read_cnt = 0;
  int data_cnt = 0;
  int fd_cnt = 0;
  int fd_at_data = -1;
  int fd_log_idx = -1;
  int last_issue_cyc = -1;
  int last_data_gap = -1;
  logic [2:0] log_cmd[$];
  logic [7:0] log_byte[$];

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  // Event n of the ideal output stream after reset: reset pulse, six init bytes,
  // then per page three setup bytes followed by (read, data byte) per column.
  function automatic void model_event(input int n, output bit is_read, output bit is_data,
                                      output int ecmd, output int ebyte, output bit efd,
                                      output int pg, output int col);
    int j, pos, q;
    is_read = 0; is_data = 0; ecmd = 0; ebyte = 0; efd = 0; pg = 0; col = 0;
    if (n == 0) begin
      ecmd = 1;
    end else if (n <= 6) begin
      ecmd = 2;
      ebyte = int'(INIT_BYTES[n-1]);
    end else begin
      j = n - 7;
      pos = j % 259;
      pg = (j / 259) % 8;
      if (pos < 3) begin
        ecmd = 2;
        ebyte = (pos == 0) ? (8'hB0 + pg) : ((pos == 1) ? 8'h00 : 8'h10);
      end else begin
        q = pos - 3;
        col = q / 2;
        if (q % 2 == 0) begin
          is_read = 1;
        end else begin
          is_data = 1;
          ecmd = 3;
          efd = (pg == 7) && (col == 127);
        end
      end
    end
  endfunction

  always @(negedge clk) begin
    bit is_read, is_data, efd, iss;
    int ecmd, ebyte, epg, ecol;
    if (!rst_n) begin
      check("reset_outputs", {bus_if.dspi_cmd, bus_if.dspi_byte, bus_if.d_read, bus_if.d_page_idx,
                              bus_if.d_column_idx, bus_if.frame_done}, 0);
      k = 0; prev_issue = 0; arrived = 0; waiting = 0; strobe_at = -1;
      read_cyc = -1; read_pg = -1; read_col = -1;
    end else begin
      model_event(k, is_read, is_data, ecmd, ebyte, efd, epg, ecol);
      iss = (bus_if.dspi_cmd != 3'd0);
      if (iss) begin
        check("read_with_issue", bus_if.d_read, 0);
        check("issue_kind_is_read", is_read, 0);
        check("cmd", bus_if.dspi_cmd, ecmd);
        check("byte", bus_if.dspi_byte, is_data ? int'(exp_data) : ebyte);
        check("issue_ready", bus_if.dspi_ready, 1);
        check("issue_back_to_back", prev_issue, 0);
        if (is_data) check("issue_before_data", arrived, 1);
        check("frame_done", bus_if.frame_done, efd);
        log_cmd.push_back(bus_if.dspi_cmd);
        log_byte.push_back(bus_if.dspi_byte);
        last_issue_cyc = cyc;
        if (is_data) begin
          data_cnt++;
          arrived = 0;
          last_data_gap = cyc - read_cyc;
        end
        if (bus_if.frame_done) begin
          fd_cnt++;
          fd_at_data = data_cnt;
          fd_log_idx = log_cmd.size();
        end
        k++;
      end else if (bus_if.d_read) begin
        check("read_kind", is_read, 1);
        check("read_page", bus_if.d_page_idx, epg);
        check("read_column", bus_if.d_column_idx, ecol);
        check("frame_done_idle", bus_if.frame_done, 0);
        read_cyc = cyc; read_pg = epg; read_col = ecol; read_cnt++;
        if (!silent) begin
          strobe_at = cyc + $urandom_range(lat_max, lat_min);
          resp_data = rand_data ? 8'($urandom) : fix_val;
        end
        k++;
      end else begin
        check("frame_done_idle", bus_if.frame_done, 0);
        if (is_read)
          check("read_late", bus_if.d_read, 1);
        else if (bus_if.dspi_ready && !prev_issue && (!is_data || arrived))
          check("issue_late", iss, 1);
      end
      model_event(k, is_read, is_data, ecmd, ebyte, efd, epg, ecol);
      if (is_data) begin
        check("hold_page", bus_if.d_page_idx, epg);
        check("hold_column", bus_if.d_column_idx, ecol);
        if (!arrived && cyc > read_cyc) begin
          if (bus_if.d_data_ready) begin
            arrived = 1;
            exp_data = bus_if.d_data;
          end
`ifdef DISPLAY_REFRESHER_TIMEOUT_EN
          else if (cyc - read_cyc == TIMEOUT - 1) begin
            arrived = 1;
            exp_data = 8'h00;
          end
`endif
        end
      end
      waiting = is_data && !arrived;
      prev_issue = iss;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    case (ready_mode)
      0:       bus_if.dspi_ready = 1'b1;
      1:       bus_if.dspi_ready = ($urandom_range(3, 0) != 0);
      default: bus_if.dspi_ready = 1'b0;
    endcase
    if (strobe_at == cyc) begin
      bus_if.d_data_ready = 1'b1;
      bus_if.d_data = resp_data;
      strobe_at = -1;
    end else if (spurious && !waiting && $urandom_range(3, 0) == 0) begin
      bus_if.d_data_ready = 1'b1;
      bus_if.d_data = 8'($urandom);
    end else begin
      bus_if.d_data_ready = 1'b0;
      bus_if.d_data = 8'($urandom);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) step();
    log_cmd.delete();
    log_byte.delete();
    rst_n = 1'b1;
  endtask

  initial begin
    int base, rc, up_cyc, i;
    bus_if.dspi_ready = 1'b0;
    bus_if.d_data_ready = 1'b0;
    bus_if.d_data = 8'h00;

    // Full frame with always-ready engine and a 2-cycle source answering 0x5A.
    ready_mode = 0; lat_min = 2; lat_max = 2; rand_data = 0; fix_val = 8'h5A;
    do_reset();
    for (i = 0; i < 6000 && fd_cnt == 0; i++) step();
    check("frame_done_seen", fd_cnt, 1);
    check("frame_data_count", fd_at_data, 1024);
    repeat (12) step();
    check("frame_done_once", fd_cnt, 1);
    check("log_rst_cmd", log_cmd[0], 1);
    check("log_init0", log_byte[1], 8'hAE);
    check("log_init1", log_byte[2], 8'h8D);
    check("log_init5", log_byte[6], 8'hAF);
    check("log_pg0", log_byte[7], 8'hB0);
    check("log_lo0", log_byte[8], 8'h00);
    check("log_hi0", log_byte[9], 8'h10);
    check("log_first_data_cmd", log_cmd[10], 3);
    check("log_first_data", log_byte[10], 8'h5A);
    check("log_pg1", log_byte[138], 8'hB1);
    check("log_pg1_lo", log_byte[139], 8'h00);
    check("log_pg1_hi", log_byte[140], 8'h10);
    check("after_frame_pg", log_byte[fd_log_idx], 8'hB0);
    check("after_frame_lo", log_byte[fd_log_idx+1], 8'h00);
    check("after_frame_hi", log_byte[fd_log_idx+2], 8'h10);

    // Random engine readiness, random latency and data, stray strobes.
    ready_mode = 1; lat_min = 1; lat_max = 8; rand_data = 1; spurious = 1;
    repeat (4000) step();
    spurious = 0;

    // Engine busy for 20 cycles while a data byte is pending.
    ready_mode = 0; lat_min = 3; lat_max = 3;
    for (i = 0; i < 200 && !(waiting && strobe_at == cyc + 1); i++) step();
    check("stall_setup", waiting && strobe_at == cyc + 1, 1);
    step();
    base = data_cnt; rc = read_cnt;
    ready_mode = 2;
    repeat (20) step();
    check("stall_no_data", data_cnt, base);
    check("stall_no_read", read_cnt, rc);
    ready_mode = 0;
    step();
    up_cyc = cyc;
    step();
    check("stall_release_cycle", last_issue_cyc, up_cyc);
    check("stall_release_count", data_cnt, base + 1);

    // Reset while waiting on page 3, column 40.
    rand_data = 1; lat_min = 6; lat_max = 6;
    do_reset();
    for (i = 0; i < 8000 && !(read_pg == 3 && read_col == 40 && waiting); i++) step();
    check("reached_p3c40", read_pg == 3 && read_col == 40 && waiting, 1);
    step();
    check("pre_reset_page", bus_if.d_page_idx, 3);
    check("pre_reset_col", bus_if.d_column_idx, 40);
    rst_n = 1'b0;
    #1;
    check("async_reset_page", bus_if.d_page_idx, 0);
    check("async_reset_col", bus_if.d_column_idx, 0);
    check("async_reset_cmd", bus_if.dspi_cmd, 0);
    do_reset();
    repeat (20) step();
    check("restart_cmd1", log_cmd[0], 1);
    check("restart_init0", log_byte[1], 8'hAE);

    // Content source that never answers.
    silent = 1;
    rc = read_cnt;
    for (i = 0; i < 500 && read_cnt == rc; i++) step();
    check("silent_read_seen", read_cnt, rc + 1);
    base = data_cnt;
    repeat (40) step();
`ifdef DISPLAY_REFRESHER_TIMEOUT_EN
    check("timeout_progress", data_cnt > base, 1);
    check("timeout_gap", last_data_gap, TIMEOUT);
`else
    check("silent_no_data", data_cnt, base);
    check("silent_no_read", read_cnt, rc + 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
